// File: rtl/serial_bus_arbiter_if.sv
// Handshake and status signals between the two bus initiators, the split
// target and the serial bus arbiter.
interface serial_bus_arbiter_if;
  logic req0;
  logic req1;
  logic target_split;
  logic split_ready;
  logic grant0;
  logic grant1;
  logic bus_owner;
  logic bus_busy;
  logic split_pending;
  logic split_owner;
  logic timeout;

  // Arbiter side
  modport slave (
    input  req0, req1, target_split, split_ready,
    output grant0, grant1, bus_owner, bus_busy, split_pending, split_owner, timeout
  );

  // Initiator / target side
  modport master (
    output req0, req1, target_split, split_ready,
    input  grant0, grant1, bus_owner, bus_busy, split_pending, split_owner, timeout
  );
endinterface

// File: rtl/serial_bus_arbiter.sv
// Two-initiator arbiter for the shared serial bus. Initiator 0 has fixed
// priority. An initiator whose target answers with a split is parked until the
// target reports ready, and is then regranted ahead of everyone. A hold
// watchdog revokes a grant that is held too long and locks that initiator out
// until it drops its request once.
module serial_bus_arbiter #(
  parameter int MAX_HOLD = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_bus_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t        state;
  logic [CW-1:0] hold_cnt;
  logic          pend;
  logic          owner;
  logic          resume;
  logic          timeout_q;
  logic [1:0]    lock;

  logic [1:0]    req;
  logic [1:0]    eff;
  logic          cur;
  logic          hold_last;

  assign req       = {bus.req1, bus.req0};
  assign cur       = (state == GNT1);
  assign hold_last = (hold_cnt == CW'(MAX_HOLD - 1));

  // A parked initiator is invisible until its target is ready; a timed-out
  // initiator is invisible until it has released its request once.
  assign eff[0] = req[0] & ~lock[0] & ~(pend & ~owner & ~resume);
  assign eff[1] = req[1] & ~lock[1] & ~(pend &  owner & ~resume);

  // Arbitration FSM plus split, resume, lock and hold-counter bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      pend      <= 1'b0;
      owner     <= 1'b0;
      resume    <= 1'b0;
      timeout_q <= 1'b0;
      lock      <= 2'b00;
    end else begin
      timeout_q <= 1'b0;
      if (bus.split_ready && pend) resume <= 1'b1;
      if (!req[0]) lock[0] <= 1'b0;
      if (!req[1]) lock[1] <= 1'b0;
      case (state)
        IDLE: begin
          // Counter is held at zero here so every grant starts from zero.
          hold_cnt <= '0;
          if (pend && resume && eff[owner]) begin
            state  <= owner ? GNT1 : GNT0;
            pend   <= 1'b0;
            resume <= 1'b0;
          end else if (eff[0]) begin
            state <= GNT0;
          end else if (eff[1]) begin
            state <= GNT1;
          end
        end
        GNT0, GNT1: begin
          if (hold_cnt != CW'(MAX_HOLD)) hold_cnt <= hold_cnt + 1'b1;
          if (bus.target_split && !pend) begin
            // A second split while one is parked is ignored (only one slot).
            owner  <= cur;
            pend   <= 1'b1;
            resume <= 1'b0;
            state  <= IDLE;
          end else if (!req[cur]) begin
            state <= IDLE;
          end else if (hold_last) begin
            state     <= IDLE;
            timeout_q <= 1'b1;
            lock[cur] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant0        = (state == GNT0);
  assign bus.grant1        = (state == GNT1);
  assign bus.bus_owner     = (state == GNT1);
  assign bus.bus_busy      = (state != IDLE);
  assign bus.split_pending = pend;
  assign bus.split_owner   = owner;
  assign bus.timeout       = timeout_q;
endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter with an 8-cycle hold limit.
// Outputs are viewed as one vector:
// {grant0, grant1, bus_owner, bus_busy, split_pending, split_owner, timeout}
// where split_owner is only looked at while split_pending is high.
module tb_serial_bus_arbiter;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [6:0] obs;

  serial_bus_arbiter_if bus ();

  serial_bus_arbiter #(.MAX_HOLD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {bus.grant0, bus.grant1, bus.bus_owner, bus.bus_busy,
                bus.split_pending, bus.split_pending & bus.split_owner, bus.timeout};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.target_split = 1'b0; bus.split_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (obs !== 7'b0000000) begin n_err++; $display("FAIL reset_async: got %b want %b", obs, 7'b0000000); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (obs !== 7'b0000000) begin n_err++; $display("FAIL reset_release: got %b want %b", obs, 7'b0000000); end
  endtask

  task automatic test_priority();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    tick();
    n_cmp++; if (obs !== 7'b1001000) begin n_err++; $display("FAIL prio_grant0: got %b want %b", obs, 7'b1001000); end
    bus.req0 = 1'b0;
    tick();
    n_cmp++; if (obs !== 7'b0000000) begin n_err++; $display("FAIL prio_turnaround: got %b want %b", obs, 7'b0000000); end
    tick();
    n_cmp++; if (obs !== 7'b0111000) begin n_err++; $display("FAIL prio_grant1: got %b want %b", obs, 7'b0111000); end
  endtask

  // Enters with GNT1 active and req1 held; leaves in GNT1 with req0=req1=1.
  task automatic test_split_resume();
    bus.target_split = 1'b1;
    tick();
    bus.target_split = 1'b0;
    n_cmp++; if (obs !== 7'b0000110) begin n_err++; $display("FAIL split_park: got %b want %b", obs, 7'b0000110); end
    tick();
    n_cmp++; if (obs !== 7'b0000110) begin n_err++; $display("FAIL split_req1_masked: got %b want %b", obs, 7'b0000110); end
    bus.req0 = 1'b1;
    tick();
    n_cmp++; if (obs !== 7'b1001110) begin n_err++; $display("FAIL split_grant0: got %b want %b", obs, 7'b1001110); end
    bus.split_ready = 1'b1;
    tick();
    bus.split_ready = 1'b0;
    n_cmp++; if (obs !== 7'b1001110) begin n_err++; $display("FAIL split_ready_hold0: got %b want %b", obs, 7'b1001110); end
    bus.req0 = 1'b0;
    tick();
    n_cmp++; if (obs !== 7'b0000110) begin n_err++; $display("FAIL split_release0: got %b want %b", obs, 7'b0000110); end
    tick();
    n_cmp++; if (obs !== 7'b0111000) begin n_err++; $display("FAIL split_resume1: got %b want %b", obs, 7'b0111000); end
    // Same again, but req0 comes back at the edge where resume is eligible.
    bus.target_split = 1'b1;
    tick();
    bus.target_split = 1'b0;
    n_cmp++; if (obs !== 7'b0000110) begin n_err++; $display("FAIL split2_park: got %b want %b", obs, 7'b0000110); end
    bus.req0 = 1'b1;
    tick();
    n_cmp++; if (obs !== 7'b1001110) begin n_err++; $display("FAIL split2_grant0: got %b want %b", obs, 7'b1001110); end
    bus.split_ready = 1'b1;
    tick();
    bus.split_ready = 1'b0;
    bus.req0 = 1'b0;
    tick();
    n_cmp++; if (obs !== 7'b0000110) begin n_err++; $display("FAIL split2_release0: got %b want %b", obs, 7'b0000110); end
    bus.req0 = 1'b1;
    tick();
    n_cmp++; if (obs !== 7'b0111000) begin n_err++; $display("FAIL split2_resume_beats_req0: got %b want %b", obs, 7'b0111000); end
  endtask

  // Enters in GNT1 with both requests high; leaves fully idle.
  task automatic test_second_split();
    bus.target_split = 1'b1;
    tick();
    bus.target_split = 1'b0;
    tick();
    n_cmp++; if (obs !== 7'b1001110) begin n_err++; $display("FAIL split3_grant0: got %b want %b", obs, 7'b1001110); end
    bus.target_split = 1'b1;
    tick();
    bus.target_split = 1'b0;
    n_cmp++; if (obs !== 7'b1001110) begin n_err++; $display("FAIL split3_ignored: got %b want %b", obs, 7'b1001110); end
    bus.req0 = 1'b0;
    tick();
    bus.split_ready = 1'b1;
    tick();
    bus.split_ready = 1'b0;
    tick();
    n_cmp++; if (obs !== 7'b0111000) begin n_err++; $display("FAIL split3_resume1: got %b want %b", obs, 7'b0111000); end
    bus.req1 = 1'b0;
    tick();
    tick();
    n_cmp++; if (obs !== 7'b0000000) begin n_err++; $display("FAIL split3_idle: got %b want %b", obs, 7'b0000000); end
  endtask

  task automatic test_watchdog();
    bus.req0 = 1'b1;
    tick();
    n_cmp++; if (obs !== 7'b1001000) begin n_err++; $display("FAIL wd_cycle1: got %b want %b", obs, 7'b1001000); end
    for (int i = 2; i <= 8; i++) begin
      tick();
      n_cmp++; if (obs !== 7'b1001000) begin n_err++; $display("FAIL wd_hold_cycle%0d: got %b want %b", i, obs, 7'b1001000); end
    end
    tick();
    n_cmp++; if (obs !== 7'b0000001) begin n_err++; $display("FAIL wd_timeout: got %b want %b", obs, 7'b0000001); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (obs !== 7'b0000000) begin n_err++; $display("FAIL wd_locked%0d: got %b want %b", i, obs, 7'b0000000); end
    end
    bus.req0 = 1'b0;
    tick();
    bus.req0 = 1'b1;
    tick();
    n_cmp++; if (obs !== 7'b1001000) begin n_err++; $display("FAIL wd_unlock_grant: got %b want %b", obs, 7'b1001000); end
    bus.req0 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_simultaneous();
    bus.req1 = 1'b1;
    tick();
    n_cmp++; if (obs !== 7'b0111000) begin n_err++; $display("FAIL sim_grant1: got %b want %b", obs, 7'b0111000); end
    bus.target_split = 1'b1;
    bus.req1 = 1'b0;
    tick();
    bus.target_split = 1'b0;
    n_cmp++; if (obs !== 7'b0000110) begin n_err++; $display("FAIL sim_split_over_release: got %b want %b", obs, 7'b0000110); end
    bus.req0 = 1'b1;
    tick();
    n_cmp++; if (obs !== 7'b1001110) begin n_err++; $display("FAIL sim_grant0_pending: got %b want %b", obs, 7'b1001110); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (obs !== 7'b0000000) begin n_err++; $display("FAIL sim_async_reset: got %b want %b", obs, 7'b0000000); end
    bus.req0 = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    n_cmp++; if (obs !== 7'b0000000) begin n_err++; $display("FAIL sim_after_reset: got %b want %b", obs, 7'b0000000); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_priority();
    test_split_resume();
    test_second_split();
    test_watchdog();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL run_time_limit: simulation did not finish within bound");
    $fatal(1);
  end
endmodule

// File: doc/serial_bus_arbiter.md
# serial_bus_arbiter

Arbiter and split-transaction scheduler for the shared serial address/data bus. It takes `arbiter_req` from two initiator ports and returns a one-hot grant. It parks an initiator whose target signals a split, so the other initiator can use the bus meanwhile, and gives the parked initiator the bus back first once the target reports ready. A hold watchdog forcibly revokes a grant that is never released.

## Interface
- `MAX_HOLD`, default 64: grant cycles before forced revoke; width of hold counter = $clog2(MAX_HOLD+1).
- `clk` input 1: bus clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req0` input 1: bus request from initiator 0 (higher fixed priority).
- `req1` input 1: bus request from initiator 1.
- `target_split` input 1: target split response during current grant.
- `split_ready` input 1: single-cycle pulse; split target ready to complete.
- `grant0` output 1: bus granted to initiator 0.
- `grant1` output 1: bus granted to initiator 1.
- `bus_owner` output 1: index of granted initiator; 0 when idle.
- `bus_busy` output 1: a grant is active.
- `split_pending` output 1: an initiator is parked on a split.
- `split_owner` output 1: index of parked initiator; valid while `split_pending`.
- `timeout` output 1: one-cycle pulse on forced revoke.

## Operation
- States: IDLE, GNT0, GNT1. Outputs decode registered state: `grant0`=GNT0, `grant1`=GNT1, `bus_busy`=not IDLE, `bus_owner`=GNT1.
- Effective request: `effN` = `reqN` and not masked.
  - Masked while N is the split owner and resume is not set.
  - Masked while N's timeout-lock is set. The lock clears on the first cycle `reqN`=0.
- IDLE arbitration, in priority order:
  1. Resume: split pending, resume flag set and `eff` of owner high. Go to owner's GNT, clear `split_pending` and resume.
  2. `eff0` goes to GNT0.
  3. `eff1` goes to GNT1.
  4. Otherwise stay in IDLE.
- GNTx exits, in priority order:
  1. `target_split`=1 with no split pending: record `split_owner`=x, set `split_pending`, go to IDLE.
  2. `target_split`=1 with a split already pending: ignored, grant continues.
  3. `reqx`=0: go to IDLE.
  4. Hold counter = MAX_HOLD-1: go to IDLE, pulse `timeout`, set x's timeout-lock.
- Every grant goes through at least one IDLE cycle for bus turnaround. No back-to-back grants.
- `split_ready` while `split_pending` sets the resume flag. The flag stays set until the owner is regranted.
- `split_ready` with no split pending is ignored.
- Hold counter clears on entry to GNTx and increments each GNT cycle. It saturates, never wraps.

## Timing
- Reset (asynchronous): state IDLE, all outputs 0. `split_pending`, resume, locks and counter cleared.
  - Reset mid-grant drops the grant immediately, without waiting for a clock edge.
- Grant latency: `reqN` sampled high at edge k in IDLE gives `grantN`=1 after edge k, a 1-cycle latency.
- Release: `reqx`=0 sampled at edge k gives `grantx`=0 after edge k. The earliest next grant follows edge k+1.
- Split: `target_split` sampled at edge k gives grant low and `split_pending`=1 after edge k. The other initiator can be granted after edge k+1.
- Simultaneous events:
  - `target_split` with `reqx`=0: split wins.
  - `target_split` with hold expiry: split wins, no `timeout`.
  - `split_ready` with a new `target_split`: the new split is recorded with resume=0.
  - Resume eligible with `req0`: resume wins over fixed priority.
- `timeout` is high for exactly the cycle after the revoking edge, coincident with IDLE.

## Test plan
- **Reset, then fixed priority.**
  - Reset, then `req0`=`req1`=1 at the same edge: `grant0` next cycle, `grant1`=0.
  - Drop `req0`: one IDLE cycle, then `grant1`=1, `bus_owner`=1.
- **Split and resume.**
  - GNT1 active, pulse `target_split`: `grant1`=0, `split_pending`=1, `split_owner`=1, and `req1` is ignored.
  - `req0` gets granted during the split.
  - Pulse `split_ready` while `req0` is held: after `req0` drops, `grant1`=1 and `split_pending`=0.
  - Repeat with `req0` re-raised at the same edge: `grant1` still wins.
- **Second split while pending.** Initiator 1 is parked and GNT0 receives `target_split`: `grant0` stays 1 and `split_owner` stays 1.
- **Watchdog, MAX_HOLD=8.**
  - Hold `req0` high: `grant0` high for exactly 8 cycles, then `timeout` pulses once.
  - `grant0` stays 0 until `req0` is lowered for one cycle and raised again.
- **Simultaneous events.** Drive `target_split` and `req1`=0 at the same edge in GNT1: a split is recorded, not a plain release.
  - Assert `rst_n`=0 during GNT0 with a split pending: all outputs go to 0 at once and `split_pending` is cleared.
